// File: rtl/riscv_cm_sequencer.sv
// riscv_cm_sequencer: orders captured cache-maintenance commands into a D$ op then an I$ invalidate, stalling fetch until retired
// Ports:
//   clk_i, rst_ni                                   clock, asynchronous active-low reset
//   cm_dc_clean_i, cm_dc_invalidate_i,
//   cm_ic_invalidate_i                              one-cycle command pulses from the branch unit
//   dc_req_o, dc_clean_o, dc_invalidate_o, dc_ack_i D$ maintenance handshake
//   ic_req_o, ic_ack_i                              I$ invalidate handshake
//   cm_stall_o                                      hold fetch/PC update (combinational)
//   cm_busy_o, cm_done_o, cm_timeout_o              status: not idle, sequence retired pulse, sticky watchdog flag
module riscv_cm_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cm_dc_clean_i,
    input  logic cm_dc_invalidate_i,
    input  logic cm_ic_invalidate_i,
    output logic dc_req_o,
    output logic dc_clean_o,
    output logic dc_invalidate_o,
    input  logic dc_ack_i,
    output logic ic_req_o,
    input  logic ic_ack_i,
    output logic cm_stall_o,
    output logic cm_busy_o,
    output logic cm_done_o,
    output logic cm_timeout_o
);
    typedef enum logic [1:0] {IDLE, DC_REQ, IC_REQ, DONE} state_t;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    state_t state, nxt;
    logic [2:0] pend, act, cmd, src;
    logic [CW-1:0] cnt;
    logic in_req, ack, wd, fire, launch;
    always_comb begin
        cmd    = {cm_dc_clean_i, cm_dc_invalidate_i, cm_ic_invalidate_i};
        src    = pend | cmd;
        in_req = state == DC_REQ || state == IC_REQ;
        ack    = state == DC_REQ ? dc_ack_i : state == IC_REQ ? ic_ack_i : 1'b0;
        wd     = TIMEOUT_CYCLES > 0 && cnt == CW'(TIMEOUT_CYCLES - 1);
        fire   = in_req && (ack || wd);
        // a new sequence may start from IDLE or straight out of DONE
        launch = (state == IDLE || state == DONE) && |src;
        nxt    = launch ? (|src[2:1] ? DC_REQ : IC_REQ) :
                 state == DONE ? IDLE :
                 fire ? ((state == DC_REQ && act[0]) ? IC_REQ : DONE) : state;
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            pend            <= '0;
            act             <= '0;
            cnt             <= '0;
            dc_req_o        <= 1'b0;
            dc_clean_o      <= 1'b0;
            dc_invalidate_o <= 1'b0;
            ic_req_o        <= 1'b0;
            cm_done_o       <= 1'b0;
            cm_timeout_o    <= 1'b0;
        end else begin
            state           <= nxt;
            pend            <= launch ? 3'b0 : src;
            act             <= launch ? src : act;
            cnt             <= nxt != state ? '0 : cnt + CW'(in_req);
            dc_req_o        <= nxt == DC_REQ;
            dc_clean_o      <= nxt == DC_REQ && (launch ? src[2] : act[2]);
            dc_invalidate_o <= nxt == DC_REQ && (launch ? src[1] : act[1]);
            ic_req_o        <= nxt == IC_REQ;
            cm_done_o       <= nxt == DONE;
            cm_timeout_o    <= cm_timeout_o | (in_req && !ack && wd);
        end
    end
    assign cm_busy_o  = state != IDLE;
    // DONE does not stall by itself, so fetch resumes in the done cycle when nothing is queued
    assign cm_stall_o = in_req | |cmd | |pend;
endmodule

// File: tb/tb_riscv_cm_sequencer.sv
// tb_riscv_cm_sequencer: randomized and directed checks of riscv_cm_sequencer against an operation-queue model
module tb_riscv_cm_sequencer;
    localparam int T = 8;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic cm_dc_clean_i = 1'b0, cm_dc_invalidate_i = 1'b0, cm_ic_invalidate_i = 1'b0;
    logic dc_ack_i = 1'b0, ic_ack_i = 1'b0;
    logic dc_req_o, dc_clean_o, dc_invalidate_o, ic_req_o;
    logic cm_stall_o, cm_busy_o, cm_done_o, cm_timeout_o;
    int checks = 0, errors = 0;
    logic [7:0] obs;
    int q[$];
    logic [1:0] dcb;
    logic [2:0] mpend;
    int age;
    logic mto;
    riscv_cm_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cm_dc_clean_i(cm_dc_clean_i), .cm_dc_invalidate_i(cm_dc_invalidate_i),
        .cm_ic_invalidate_i(cm_ic_invalidate_i),
        .dc_req_o(dc_req_o), .dc_clean_o(dc_clean_o), .dc_invalidate_o(dc_invalidate_o),
        .dc_ack_i(dc_ack_i), .ic_req_o(ic_req_o), .ic_ack_i(ic_ack_i),
        .cm_stall_o(cm_stall_o), .cm_busy_o(cm_busy_o), .cm_done_o(cm_done_o),
        .cm_timeout_o(cm_timeout_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask
    task automatic mreset();
        q.delete();
        dcb = 2'b0;
        mpend = 3'b0;
        age = 0;
        mto = 1'b0;
    endtask
    // head of the queue: 0 idle, 1 D$ op, 2 I$ op, 3 done cycle
    function automatic logic [7:0] model_out(input logic [2:0] c);
        int h;
        h = q.size() > 0 ? q[0] : 0;
        return {h == 1, h == 1 && dcb[1], h == 1 && dcb[0], h == 2,
                h == 1 || h == 2 || |c || |mpend, q.size() > 0, h == 3, mto};
    endfunction
    task automatic model_step(input logic [2:0] c, input logic da, input logic ia);
        int h;
        logic [2:0] src;
        logic acked;
        h = q.size() > 0 ? q[0] : 0;
        src = mpend | c;
        if (h == 0 || h == 3) begin
            if (h == 3) void'(q.pop_front());
            if (src != 3'b0) begin
                if (|src[2:1]) begin
                    q.push_back(1);
                    dcb = src[2:1];
                end
                if (src[0]) q.push_back(2);
                q.push_back(3);
                mpend = 3'b0;
                age = 0;
            end else mpend = src;
        end else begin
            mpend = src;
            acked = h == 1 ? da : ia;
            if (acked || age == T - 1) begin
                if (!acked) mto = 1'b1;
                void'(q.pop_front());
                age = 0;
            end else age++;
        end
    endtask
    task automatic cyc(input logic [2:0] c, input logic da, input logic ia);
        @(negedge clk_i);
        {cm_dc_clean_i, cm_dc_invalidate_i, cm_ic_invalidate_i} = c;
        dc_ack_i = da;
        ic_ack_i = ia;
        #1;
        obs = {dc_req_o, dc_clean_o, dc_invalidate_o, ic_req_o, cm_stall_o, cm_busy_o, cm_done_o, cm_timeout_o};
        chk("cycle", obs, model_out(c));
        model_step(c, da, ia);
    endtask
    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        {cm_dc_clean_i, cm_dc_invalidate_i, cm_ic_invalidate_i, dc_ack_i, ic_ack_i} = '0;
        #1;
        obs = {dc_req_o, dc_clean_o, dc_invalidate_o, ic_req_o, cm_stall_o, cm_busy_o, cm_done_o, cm_timeout_o};
        chk("reset_state", obs, 8'h00);
        mreset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask
    initial begin
        int n, m, all;
        int p;
        logic [2:0] c;
        mreset();
        do_reset();
        // FENCE.I with acks held high
        cyc(3'b101, 1, 1); chk("t1_c0", obs, 8'b0000_1000);
        cyc(3'b000, 1, 1); chk("t1_c1", obs, 8'b1100_1100);
        cyc(3'b000, 1, 1); chk("t1_c2", obs, 8'b0001_1100);
        cyc(3'b000, 1, 1); chk("t1_c3", obs, 8'b0000_0110);
        cyc(3'b000, 0, 0); chk("t1_c4", obs, 8'b0000_0000);
        // ic_inv only, ack five cycles late
        n = 0; m = 0;
        cyc(3'b001, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            cyc(3'b000, 0, i == 6);
            n += int'(obs[4]);
            m += int'(obs[7]);
        end
        chk("t2_icreq_cycles", 8'(n), 8'd6);
        chk("t2_no_dcreq", 8'(m), 8'd0);
        chk("t2_done", obs, 8'b0000_0110);
        cyc(3'b000, 0, 0);
        // combined clean+invalidate
        cyc(3'b110, 1, 0);
        cyc(3'b000, 1, 0); chk("t3_combined", obs, 8'b1110_1100);
        cyc(3'b000, 1, 0); chk("t3_done", obs, 8'b0000_0110);
        cyc(3'b000, 0, 0); chk("t3_idle", obs, 8'b0000_0000);
        // merged command during DC_REQ
        n = 0; all = 1;
        for (int i = 0; i <= 7; i++) begin
            cyc(i == 0 ? 3'b101 : i == 1 ? 3'b001 : 3'b000, i == 2, i == 3 || i == 5);
            n += int'(obs[1]);
            if (i <= 5) all &= int'(obs[3]);
        end
        chk("t4_dones", 8'(n), 8'd2);
        chk("t4_stall_held", 8'(all), 8'd1);
        // watchdog on a hung D$
        n = 0;
        cyc(3'b101, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(3'b000, 0, 1);
            n += int'(obs[7]);
        end
        chk("t5_dcreq_cycles", 8'(n), 8'd8);
        cyc(3'b000, 0, 1); chk("t5_icreq", obs, 8'b0001_1101);
        cyc(3'b000, 0, 1); chk("t5_done", obs, 8'b0000_0111);
        cyc(3'b000, 0, 0); chk("t5_sticky", obs, 8'b0000_0001);
        do_reset();
        // randomized traffic with varying ack responsiveness
        for (int b = 0; b < 15; b++) begin
            p = b % 3 == 0 ? 0 : b % 3 == 1 ? 3 : 14;
            for (int i = 0; i < 200; i++) begin
                c = $urandom_range(0, 5) == 0 ? 3'($urandom_range(1, 7)) : 3'b000;
                cyc(c, $urandom_range(0, p) == 0, $urandom_range(0, p) == 0);
            end
        end
        do_reset();
        // reset while in IC_REQ
        cyc(3'b001, 0, 0);
        cyc(3'b000, 0, 0);
        cyc(3'b000, 0, 0); chk("t6_in_icreq", obs, 8'b0001_1100);
        @(negedge clk_i);
        cm_ic_invalidate_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("t6_async_drop", {ic_req_o, cm_stall_o, cm_busy_o, cm_done_o}, 8'h00);
        mreset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(3'b000, 0, 0);
            n += int'(obs[1]) + int'(obs[2]);
        end
        chk("t6_no_done_after", 8'(n), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
